// File: rtl/sync_ram_bist_pkg.sv
// Shared types and the pattern generator for the sync_ram BIST.
package sync_ram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE, WR0, RD0, DRN0, WR1, RD1, DRN1, DONE
    } state_e;

    // Pattern for one address. The caller truncates the result to its data
    // width, which gives the modulo-2**DATA_W behaviour.
    function automatic logic [31:0] pat(input logic [31:0] seed,
                                        input logic [31:0] addr,
                                        input logic        inv);
        logic [31:0] p;
        p = seed + addr;
        return inv ? ~p : p;
    endfunction

endpackage

// File: rtl/sync_ram_bist_if.sv
// Single-port RAM bus. The BIST is the master and the RAM is the slave.
interface sync_ram_bist_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    modport master (output ram_en, ram_we, ram_addr, ram_din, input ram_dout);
    modport slave  (input ram_en, ram_we, ram_addr, ram_din, output ram_dout);
endinterface

// File: rtl/sync_ram_bist_chk.sv
// Read-compare stage: it holds each read's expected value for one cycle,
// compares that value against ram_dout, and counts and records mismatches.
module sync_ram_bist_chk
    import sync_ram_bist_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              rd_issue,
    input  logic              rd_pass,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] expected,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic              first_fail_pass
);
    logic              vld_q, pass_q, seen_q, ffp_q;
    logic [ADDR_W-1:0] addr_q, ffa_q;
    logic [DATA_W-1:0] exp_q;
    logic [ERR_W-1:0]  err_q;
    logic              mismatch;

    // The RAM returns data one cycle after the read edge, so the registered
    // expected value lines up with ram_dout here.
    assign mismatch = vld_q && (ram_dout != exp_q);

    // Pipeline register, saturating counter, and first-fail capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            pass_q <= 1'b0;
            addr_q <= '0;
            exp_q  <= '0;
            err_q  <= '0;
            seen_q <= 1'b0;
            ffa_q  <= '0;
            ffp_q  <= 1'b0;
        end else begin
            vld_q  <= rd_issue && !clear;
            pass_q <= rd_pass;
            addr_q <= addr;
            exp_q  <= expected;
            if (clear) begin
                err_q  <= '0;
                seen_q <= 1'b0;
                ffa_q  <= '0;
                ffp_q  <= 1'b0;
            end else if (mismatch) begin
                if (err_q != {ERR_W{1'b1}})
                    err_q <= err_q + ERR_W'(1);
                if (!seen_q) begin
                    seen_q <= 1'b1;
                    ffa_q  <= addr_q;
                    ffp_q  <= pass_q;
                end
            end
        end
    end

    assign err_cnt         = err_q;
    assign first_fail_addr = ffa_q;
    assign first_fail_pass = ffp_q;
endmodule

// File: rtl/sync_ram_bist.sv
// BIST initiator for sync_ram. It runs a write/read-compare walk with the
// true pattern, then repeats the walk with the inverted pattern.
module sync_ram_bist
    import sync_ram_bist_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [DATA_W-1:0]      seed,
    sync_ram_bist_if.master        ram,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [ERR_W-1:0]       err_cnt,
    output logic [ADDR_W-1:0]      first_fail_addr,
    output logic                   first_fail_pass
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic              accept, last;
    logic              en_q, en_d, we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              rd_issue, rd_pass;
    logic [DATA_W-1:0] rd_exp;

    assign last = &cnt_q;

    // Next state and counter. The RAM drive is computed from the next state,
    // so that the port registers line up with the state the FSM enters.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seed_d  = seed_q;
        accept  = 1'b0;
        case (state_q)
            IDLE, DONE: if (start) begin
                accept  = 1'b1;
                state_d = WR0;
                cnt_d   = '0;
                seed_d  = seed;
            end
            WR0:  begin cnt_d = cnt_q + ADDR_W'(1); if (last) state_d = RD0; end
            RD0:  begin cnt_d = cnt_q + ADDR_W'(1); if (last) state_d = DRN0; end
            DRN0: state_d = WR1;
            WR1:  begin cnt_d = cnt_q + ADDR_W'(1); if (last) state_d = RD1; end
            RD1:  begin cnt_d = cnt_q + ADDR_W'(1); if (last) state_d = DRN1; end
            DRN1: state_d = DONE;
            default: state_d = IDLE;
        endcase

        we_d   = (state_d == WR0) || (state_d == WR1);
        en_d   = we_d || (state_d == RD0) || (state_d == RD1);
        addr_d = en_d ? cnt_d : '0;
        din_d  = we_d ? DATA_W'(pat(32'(seed_d), 32'(cnt_d), state_d == WR1)) : '0;
    end

    // State, counter, captured seed, and registered RAM port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            seed_q  <= '0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seed_q  <= seed_d;
            en_q    <= en_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    assign ram.ram_en   = en_q;
    assign ram.ram_we   = we_q;
    assign ram.ram_addr = addr_q;
    assign ram.ram_din  = din_q;

    // The read being issued this cycle is the one on the port, in RDx state.
    assign rd_issue = (state_q == RD0) || (state_q == RD1);
    assign rd_pass  = (state_q == RD1);
    assign rd_exp   = DATA_W'(pat(32'(seed_q), 32'(cnt_q), rd_pass));

    sync_ram_bist_chk #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERR_W(ERR_W)) u_chk (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear           (accept),
        .rd_issue        (rd_issue),
        .rd_pass         (rd_pass),
        .addr            (cnt_q),
        .expected        (rd_exp),
        .ram_dout        (ram.ram_dout),
        .err_cnt         (err_cnt),
        .first_fail_addr (first_fail_addr),
        .first_fail_pass (first_fail_pass)
    );

    assign busy = (state_q != IDLE) && (state_q != DONE);
    assign done = (state_q == DONE);
    assign pass = done && (err_cnt == '0);
endmodule

// File: doc/sync_ram_bist.md
Name: sync_ram_bist

Overview:
Built-in self-test initiator for the team's single-port `sync_ram`. It drives the RAM's en/we/addr/din port and consumes dout.
- On `start`, it runs a two-pass walk over every address: write a pattern, read it back and compare, then repeat with the inverted pattern.
- It reports pass/fail, an error count and the first failing address.
- It sits between the RAM and the system test/status logic. In mission mode the RAM port is muxed away from it, outside this block.

Parameters:
- ADDR_W, 4, RAM address width; DEPTH = 2**ADDR_W.
- DATA_W, 8, RAM data width.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  rising-edge clock, shared with `sync_ram`.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run request, sampled only in IDLE or DONE.
- seed  in  DATA_W  pattern seed, captured on an accepted start.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable; 1 = write, 0 = read.
- ram_addr  out  ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM write data.
- ram_dout  in  DATA_W  RAM read data; valid exactly 1 cycle after the read edge.
- busy  out  1  high while a run is in progress.
- done  out  1  level-high in DONE, until the next accepted start.
- pass  out  1  valid while done is high; 1 = zero mismatches.
- err_cnt  out  ERR_W  mismatch count, saturating at all-ones.
- first_fail_addr  out  ADDR_W  address of the first mismatch in the run.
- first_fail_pass  out  1  pass (0 or 1) in which the first mismatch occurred.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0: ram_en, ram_we, ram_addr, ram_din, busy, done, pass, err_cnt, first_fail_*. Reset mid-run aborts immediately, and the RAM contents are left as-is.
- Pattern: pat(a) = (seed_q + zero-extended a) mod 2**DATA_W. Pass 0 uses pat(a); pass 1 uses ~pat(a).
- States: IDLE -> WR0 -> RD0 -> DRN0 -> WR1 -> RD1 -> DRN1 -> DONE.
- Accepting start:
  - start=1 in IDLE or DONE moves to WR0 on the next edge.
  - In the same edge: capture seed_q; clear err_cnt, first_fail_*, done, pass; set addr counter to 0.
  - start is ignored in all other states.
- WRx: one write per cycle. ram_en=1, ram_we=1, ram_addr=cnt, ram_din=pattern. After cnt=DEPTH-1, wrap cnt to 0 and go to RDx.
- RDx: one read per cycle. ram_en=1, ram_we=0, ram_addr=cnt, ram_din=0. After cnt=DEPTH-1, go to DRNx.
- DRNx: lasts 1 cycle with ram_en=0; it exists only to compare the last read.
- Compare pipeline:
  - Each read issue registers (valid, addr, expected) for one cycle.
  - In the following cycle, ram_dout is compared against the registered expected value.
  - On a mismatch, err_cnt increments (holding at 2**ERR_W-1).
  - On the first mismatch of the run, first_fail_addr and first_fail_pass latch and then stay frozen.
- DONE: done=1, pass=(err_cnt==0), busy=0, ram_en=0. The state holds until start.
- busy=1 in WR0 through DRN1 inclusive.
- Outputs ram_* are registered; they change only on clk edges.
- Run length: 4*DEPTH+2 cycles from first WR0 cycle to first DONE cycle (66 for DEPTH=16).
- Back-to-back runs: start held high in DONE restarts immediately. done drops one cycle after that edge, in WR0.

Decomposition:
- Package sync_ram_bist_pkg:
  - state enum (IDLE, WR0, RD0, DRN0, WR1, RD1, DRN1, DONE);
  - function pat(seed, addr, inv).
- Sub-module sync_ram_bist_chk: read-compare pipeline register, saturating err_cnt, first-fail capture.
  - Inputs: rd_issue, addr, expected, ram_dout, clear.
- Top: FSM, address counter, RAM port drive.

Test Plan:
1. Reset then idle. Hold rst_n=0 for 2 cycles, release, wait 5 cycles -> all outputs 0, ram_en never asserted.
2. Clean run. Bench `sync_ram` attached, seed=8'h5A, 1-cycle start pulse:
   - addr 1 is written 8'h5B in pass 0 and 8'hA4 in pass 1;
   - done rises exactly 66 cycles after the WR0 entry edge;
   - pass=1, err_cnt=0.
3. Stuck bit. Bench forces ram_dout[0] inverted whenever the read address is 4'h7 -> err_cnt=2, first_fail_addr=4'h7, first_fail_pass=0, pass=0.
4. Saturation. ERR_W=2, all reads return 8'h00, seed=8'h01 -> err_cnt=3 at done, first_fail_addr=0, pass=0.
5. Start while busy. Pulse start again 10 cycles into the run -> ignored; done still at cycle 66 and seed_q unchanged.
6. Reset mid-run. Drop rst_n during RD1 with address 5 -> outputs clear asynchronously, no RAM access for 5 cycles. A new start with seed 8'hC3 then completes with pass=1.
